hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RISC-V pipeline.
- Drives stall and flush controls for the F/D, D/E and E/M pipeline registers, plus operand-forwarding selects for the Execute stage.
- Holds the pipeline for a fixed-latency multi-cycle execute op (MUL/DIV) using an internal FSM and counter.
- Sits beside the datapath. All control outputs are combinational from stage fields plus internal state.

Parameters:
- MD_LATENCY, 4, total Execute-stage occupancy in cycles of a multi-cycle op (legal values 1..16).

Ports:
- clk  in  1  clock (all state updates on rising edge)
- reset  in  1  asynchronous, active-high reset
- Rs1D  in  5  source register 1 of the instruction in Decode
- Rs2D  in  5  source register 2 of the instruction in Decode
- Rs1E  in  5  source register 1 of the instruction in Execute
- Rs2E  in  5  source register 2 of the instruction in Execute
- RdE  in  5  destination register in Execute
- RdM  in  5  destination register in Memory
- RdW  in  5  destination register in Writeback
- RegWriteE  in  1  Execute instruction writes the register file
- RegWriteM  in  1  Memory instruction writes the register file
- RegWriteW  in  1  Writeback instruction writes the register file
- ResultSrcE0  in  1  Execute instruction is a load
- PCSrcE  in  1  taken branch or jump resolved in Execute
- MdStartE  in  1  Execute instruction is a multi-cycle op
- StallF  out  1  hold the PC register
- StallD  out  1  hold the F/D register (active-high hold)
- FlushD  out  1  clear the F/D register (NOP)
- StallE  out  1  hold the D/E register
- FlushE  out  1  clear the D/E register
- FlushM  out  1  clear the E/M register (bubble)
- ForwardAE  out  2  SrcA select: 00 = register file, 01 = ResultW, 10 = ALUResultM
- ForwardBE  out  2  SrcB select, same encoding as ForwardAE
- MdBusy  out  1  multi-cycle op currently holding the pipeline
- MdDone  out  1  one-cycle pulse in the release cycle of a multi-cycle op

Behaviour:
- Register matches: any match against a register index of 0 is ignored.
- Forwarding: ForwardAE = 10 if RegWriteM and RdM==Rs1E. Else 01 if RegWriteW and RdW==Rs1E. Else 00. Memory stage has priority. ForwardBE uses Rs2E the same way.
- Load-use: lwStall = ResultSrcE0 and RdE matches Rs1D or Rs2D.
- Multi-cycle FSM states: IDLE, RUN, DONE. Counter cnt is 4 bits.
  - IDLE: if MdStartE and MD_LATENCY>=2, assert mdStall. Next state is DONE if MD_LATENCY==2, else RUN with cnt = MD_LATENCY-3.
  - RUN: assert mdStall. If cnt==0, go to DONE; else cnt decrements.
  - DONE: no stall, MdDone=1, MdStartE ignored. Always returns to IDLE.
  - Result: MD_LATENCY-1 stall cycles, and the op occupies Execute for exactly MD_LATENCY cycles.
  - MD_LATENCY==1: FSM never leaves IDLE and MdDone never pulses.
- MdBusy = mdStall.
- Output equations:
  - StallF = lwStall | mdStall | rawStall
  - StallD = lwStall | mdStall | rawStall
  - StallE = mdStall
  - FlushM = mdStall
  - FlushD = PCSrcE
  - FlushE = (lwStall | rawStall | PCSrcE) & ~mdStall
- Exclusive conditions: load, branch and multi-cycle op in Execute are mutually exclusive by decode. No further priority is needed.
- Flush vs stall: where FlushD and StallD both assert, the flush wins, because the F/D register gives clear priority over hold.
- During mdStall, a load-use condition in Decode must not flush Execute; the masking of FlushE enforces this.
- Reset:
  - While reset is high, every output is 0, the state is IDLE and cnt is 0.
  - Reset during RUN abandons the op; the first cycle after reset is IDLE.

Optional Feature:
- Macro: HAZ_FWD_EN.
- Defined: forwarding as above, and rawStall = 0.
- Undefined:
  - ForwardAE and ForwardBE are tied to 00.
  - rawStall = (RegWriteE and RdE matches Rs1D/Rs2D) or (RegWriteM and RdM matches Rs1D/Rs2D).
  - A Writeback-stage match needs no stall because the register file writes on the falling edge.
  - lwStall is still computed; it is covered by rawStall.

Test Plan:
- Forwarding (HAZ_FWD_EN): RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then drop RegWriteM -> ForwardAE=01.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle, FlushD=0. With RdE=0 -> no stall.
- Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1, all stalls 0.
- Multi-cycle, MD_LATENCY=4: MdStartE held high -> MdBusy/StallE/FlushM high for 3 cycles, then MdDone=1 for 1 cycle with stalls low, then IDLE. Repeat with MD_LATENCY=2 (1 stall cycle) and MD_LATENCY=1 (none).
- Reset in RUN: assert reset in the 2nd stall cycle -> all outputs 0 immediately. After release with MdStartE=1, the full 3-cycle sequence restarts.
- No-forward build: RegWriteE=1, RdE=3, Rs1D=3 -> StallF=StallD=FlushE=1 and ForwardAE=00. Then RdM=3 path: stall holds one more cycle.

Source files
------------

// File: rtl/hazard_if.sv
// hazard_if: stage fields from the datapath and hazard controls back to it.
interface hazard_if;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE;
    logic       StallF, StallD, FlushD, StallE, FlushE, FlushM, MdBusy, MdDone;
    logic [1:0] ForwardAE, ForwardBE;

    modport master(
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE,
        input  StallF, StallD, FlushD, StallE, FlushE, FlushM, MdBusy, MdDone,
        input  ForwardAE, ForwardBE
    );

    modport slave(
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MdStartE,
        output StallF, StallD, FlushD, StallE, FlushE, FlushM, MdBusy, MdDone,
        output ForwardAE, ForwardBE
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage pipeline plus MUL/DIV hold FSM.
// Define HAZ_FWD_EN to forward from M/W; otherwise RAW hazards on E/M stall Decode.
module hazard_ctrl #(
    parameter int MD_LATENCY = 4
) (
    input logic clk,
    input logic reset,
    hazard_if.slave h
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] CNT_INIT = (MD_LATENCY >= 3) ? 4'(MD_LATENCY - 3) : 4'd0;
    localparam bit MULTI = MD_LATENCY >= 2;
    localparam bit SHORT = MD_LATENCY == 2;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       md_stall, md_done, lw_stall, raw_stall;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic hit(input logic [4:0] a, input logic [4:0] b);
        return (a != '0) && (a == b);
    endfunction

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        md_stall = 1'b0;
        md_done  = 1'b0;
        case (state)
            IDLE: if (h.MdStartE && MULTI) begin
                md_stall = 1'b1;
                state_n  = SHORT ? DONE : RUN;
                cnt_n    = CNT_INIT;
            end
            RUN: begin
                md_stall = 1'b1;
                state_n  = (cnt == '0) ? DONE : RUN;
                cnt_n    = (cnt == '0) ? cnt : cnt - 4'd1;
            end
            DONE: begin
                md_done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign lw_stall = h.ResultSrcE0 && (hit(h.RdE, h.Rs1D) || hit(h.RdE, h.Rs2D));

`ifdef HAZ_FWD_EN
    assign raw_stall = 1'b0;
    assign fwd_a = (h.RegWriteM && hit(h.RdM, h.Rs1E)) ? 2'b10 :
                   (h.RegWriteW && hit(h.RdW, h.Rs1E)) ? 2'b01 : 2'b00;
    assign fwd_b = (h.RegWriteM && hit(h.RdM, h.Rs2E)) ? 2'b10 :
                   (h.RegWriteW && hit(h.RdW, h.Rs2E)) ? 2'b01 : 2'b00;
`else
    // Writeback matches are safe: the register file writes on the falling edge.
    assign raw_stall = (h.RegWriteE && (hit(h.RdE, h.Rs1D) || hit(h.RdE, h.Rs2D))) ||
                       (h.RegWriteM && (hit(h.RdM, h.Rs1D) || hit(h.RdM, h.Rs2D)));
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    logic unused_fwd;
    assign unused_fwd = ^{h.Rs1E, h.Rs2E, h.RdW, h.RegWriteW};
`endif

    // Outputs are forced low while reset is held, independent of the stage fields.
    assign h.StallF    = ~reset & (lw_stall | md_stall | raw_stall);
    assign h.StallD    = ~reset & (lw_stall | md_stall | raw_stall);
    assign h.StallE    = ~reset & md_stall;
    assign h.FlushM    = ~reset & md_stall;
    assign h.FlushD    = ~reset & h.PCSrcE;
    assign h.FlushE    = ~reset & (lw_stall | raw_stall | h.PCSrcE) & ~md_stall;
    assign h.MdBusy    = ~reset & md_stall;
    assign h.MdDone    = ~reset & md_done;
    assign h.ForwardAE = reset ? 2'b00 : fwd_a;
    assign h.ForwardBE = reset ? 2'b00 : fwd_b;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl at MD_LATENCY 4, 2 and 1.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_if hi();
    hazard_if h2();
    hazard_if h1();

    hazard_ctrl #(.MD_LATENCY(4)) dut  (.clk(clk), .reset(reset), .h(hi));
    hazard_ctrl #(.MD_LATENCY(2)) dut2 (.clk(clk), .reset(reset), .h(h2));
    hazard_ctrl #(.MD_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .h(h1));

    assign h2.MdStartE = hi.MdStartE;
    assign h1.MdStartE = hi.MdStartE;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam logic [15:0] SF = 16'h8000, SD = 16'h4000, FD = 16'h2000, SE = 16'h1000;
    localparam logic [15:0] FE = 16'h0800, FM = 16'h0400, FA_M = 16'h0200, FA_W = 16'h0100;
    localparam logic [15:0] FB_M = 16'h0080, FB_W = 16'h0040, BZ = 16'h0020, DN = 16'h0010;
    localparam logic [15:0] B2 = 16'h0008, D2 = 16'h0004, B1 = 16'h0002, D1 = 16'h0001;
    localparam logic [15:0] MD = SF | SD | SE | FM | BZ;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sb[$];
    int  passed = 0;
    int  total = 0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
        else passed++;
    endtask

    always @(negedge clk)
        if (sb.size() != 0) begin
            sb_t e;
            e = sb.pop_front();
            check(e.tag, {hi.StallF, hi.StallD, hi.FlushD, hi.StallE, hi.FlushE, hi.FlushM,
                          hi.ForwardAE, hi.ForwardBE, hi.MdBusy, hi.MdDone,
                          h2.MdBusy, h2.MdDone, h1.MdBusy, h1.MdDone}, e.exp);
        end

    task automatic step(input string tag, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {hi.Rs1D, hi.Rs2D, hi.Rs1E, hi.Rs2E, hi.RdE, hi.RdM, hi.RdW, hi.RegWriteE, hi.RegWriteM,
         hi.RegWriteW, hi.ResultSrcE0, hi.PCSrcE, hi.MdStartE} = '0;
    endtask

    initial begin
        {h2.Rs1D, h2.Rs2D, h2.Rs1E, h2.Rs2E, h2.RdE, h2.RdM, h2.RdW, h2.RegWriteE, h2.RegWriteM,
         h2.RegWriteW, h2.ResultSrcE0, h2.PCSrcE} = '0;
        {h1.Rs1D, h1.Rs2D, h1.Rs1E, h1.Rs2E, h1.RdE, h1.RdM, h1.RdW, h1.RegWriteE, h1.RegWriteM,
         h1.RegWriteW, h1.ResultSrcE0, h1.PCSrcE} = '0;
        clr();
        @(posedge clk);
        #1;
        hi.PCSrcE = 1'b1;
        hi.MdStartE = 1'b1;
        step("reset_hold", 16'h0);
        reset = 1'b0;
        clr();
        step("idle", 16'h0);

        hi.RdM = 5; hi.RegWriteM = 1; hi.RdW = 5; hi.RegWriteW = 1; hi.Rs1E = 5;
        step("fwd_mem", FWD ? FA_M : 16'h0);
        hi.RegWriteM = 0;
        step("fwd_wb", FWD ? FA_W : 16'h0);
        hi.Rs2E = 5; hi.RegWriteM = 1;
        step("fwd_both_mem", FWD ? (FA_M | FB_M) : 16'h0);
        clr();
        hi.RegWriteM = 1; hi.RegWriteW = 1;
        step("fwd_x0", 16'h0);

        clr();
        hi.ResultSrcE0 = 1; hi.RegWriteE = 1; hi.RdE = 7; hi.Rs2D = 7;
        step("load_use", SF | SD | FE);
        clr();
        step("load_use_gone", 16'h0);
        hi.ResultSrcE0 = 1; hi.RegWriteE = 1;
        step("load_x0", 16'h0);

        clr();
        hi.PCSrcE = 1;
        step("branch", FD | FE);
        clr();
        step("branch_gone", 16'h0);

        hi.MdStartE = 1;
        step("md1", MD | B2);
        hi.RegWriteM = 1; hi.RdM = 9; hi.Rs1D = 9;
        step("md2_raw_masked", MD | D2);
        clr();
        hi.MdStartE = 1;
        step("md3", MD | B2);
        step("md_done", DN | D2);
        clr();
        step("md_idle", 16'h0);

        hi.MdStartE = 1;
        step("rr1", MD | B2);
        reset = 1'b1;
        step("rr_reset", 16'h0);
        step("rr_hold", 16'h0);
        reset = 1'b0;
        step("rr1b", MD | B2);
        step("rr2", MD | D2);
        step("rr3", MD | B2);
        step("rr_done", DN | D2);
        clr();
        step("rr_idle", 16'h0);

        hi.RegWriteE = 1; hi.RdE = 3; hi.Rs1D = 3;
        step("raw_e", FWD ? 16'h0 : (SF | SD | FE));
        hi.RegWriteE = 0; hi.RdE = 0; hi.RegWriteM = 1; hi.RdM = 3;
        step("raw_m", FWD ? 16'h0 : (SF | SD | FE));
        hi.PCSrcE = 1;
        step("raw_branch", FWD ? (FD | FE) : (SF | SD | FD | FE));
        hi.PCSrcE = 0; hi.RegWriteM = 0; hi.RdM = 0; hi.RegWriteW = 1; hi.RdW = 3;
        step("raw_w", 16'h0);
        clr();
        step("final", 16'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
